// File: rtl/riot.sv
// RIOT: 128x8 RAM, two 8-bit I/O ports, and an interval timer with a prescaler.
// Define RIOT_PA7_IRQ_EN to compile in the PA7 edge detector and its interrupt.
module riot #(
    parameter logic [7:0] P_DDRA_INIT  = 8'h00,
    parameter logic [7:0] P_DDRB_INIT  = 8'h00,
    parameter logic [7:0] P_TIMER_INIT = 8'hff
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       CS,
    input  logic       RAM_SEL,
    input  logic       RW,
    input  logic [6:0] ADDR,
    input  logic [7:0] DB_IN,
    output logic [7:0] DB_OUT,
    input  logic [7:0] PA_IN,
    input  logic [7:0] PB_IN,
    output logic [7:0] PA_OUT,
    output logic [7:0] PB_OUT,
    output logic [7:0] PA_DIR,
    output logic [7:0] PB_DIR,
    output logic       IRQ_N
);

    logic [7:0] ram [128];
    logic [7:0] timer;
    logic [1:0] psel;
    logic [9:0] pcnt;
    logic       forced;
    logic       tim_irq_en;
    logic       tf;
    logic       pa7f;
    logic       pa7_irq_en;

    logic wr_en, rd_en, wr_port, wr_load, rd_timer, rd_flags, dec_due;
    logic [7:0] pa_rd, pb_rd;

    assign wr_en    = CS & ~RW & ~RES;
    assign rd_en    = CS &  RW & ~RES;
    assign wr_port  = wr_en & ~RAM_SEL & ~ADDR[2];
    assign wr_load  = wr_en & ~RAM_SEL &  ADDR[2] &  ADDR[4];
    assign rd_timer = rd_en & ~RAM_SEL &  ADDR[2] & ~ADDR[0];
    assign rd_flags = rd_en & ~RAM_SEL &  ADDR[2] &  ADDR[0];
    assign dec_due  = (pcnt == 10'd0);

    assign pa_rd = (PA_IN & ~PA_DIR) | (PA_OUT & PA_DIR);
    assign pb_rd = (PB_IN & ~PB_DIR) | (PB_OUT & PB_DIR);

    function automatic logic [9:0] reload(input logic [1:0] s);
        case (s)
            2'd0:    reload = 10'd0;
            2'd1:    reload = 10'd7;
            2'd2:    reload = 10'd63;
            default: reload = 10'd1023;
        endcase
    endfunction

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_en && RAM_SEL)
            ram[ADDR] <= DB_IN;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            PA_OUT <= 8'h00;
            PB_OUT <= 8'h00;
            PA_DIR <= P_DDRA_INIT;
            PB_DIR <= P_DDRB_INIT;
        end else if (wr_port) begin
            case (ADDR[1:0])
                2'd0:    PA_OUT <= DB_IN;
                2'd1:    PA_DIR <= DB_IN;
                2'd2:    PB_OUT <= DB_IN;
                default: PB_DIR <= DB_IN;
            endcase
        end
    end

    // A load beats a due decrement; a wrap setting TF beats a clearing read.
    always_ff @(posedge CLK) begin
        if (RES) begin
            timer      <= P_TIMER_INIT;
            psel       <= 2'd3;
            pcnt       <= 10'd1023;
            forced     <= 1'b0;
            tim_irq_en <= 1'b0;
            tf         <= 1'b0;
        end else if (wr_load) begin
            timer      <= DB_IN;
            psel       <= ADDR[1:0];
            pcnt       <= reload(ADDR[1:0]);
            forced     <= 1'b0;
            tim_irq_en <= ADDR[3];
            tf         <= 1'b0;
        end else begin
            if (dec_due) begin
                timer <= timer - 8'd1;
                pcnt  <= (forced || timer == 8'h00) ? 10'd0 : reload(psel);
                if (timer == 8'h00)
                    forced <= 1'b1;
            end else begin
                pcnt <= pcnt - 10'd1;
            end
            if (rd_timer)
                tim_irq_en <= ADDR[3];
            if (dec_due && timer == 8'h00)
                tf <= 1'b1;
            else if (rd_timer)
                tf <= 1'b0;
        end
    end

`ifdef RIOT_PA7_IRQ_EN
    logic wr_edge, pa7_q, pa7_pol, pa7_edge;

    assign wr_edge  = wr_en & ~RAM_SEL & ADDR[2] & ~ADDR[4];
    assign pa7_edge = pa7_pol ? (~pa7_q & PA_IN[7]) : (pa7_q & ~PA_IN[7]);

    always_ff @(posedge CLK) begin
        if (RES) begin
            pa7_q      <= 1'b0;
            pa7_pol    <= 1'b0;
            pa7_irq_en <= 1'b0;
            pa7f       <= 1'b0;
        end else begin
            pa7_q <= PA_IN[7];
            if (wr_edge) begin
                pa7_pol    <= ADDR[0];
                pa7_irq_en <= ADDR[1];
            end
            if (pa7_edge)
                pa7f <= 1'b1;
            else if (rd_flags)
                pa7f <= 1'b0;
        end
    end
`else
    assign pa7f       = 1'b0;
    assign pa7_irq_en = 1'b0;
    logic  unused_rd_flags;
    assign unused_rd_flags = rd_flags;
`endif

    assign IRQ_N = ~((tf & tim_irq_en) | (pa7f & pa7_irq_en));

    always_comb begin
        DB_OUT = 8'h00;
        if (CS && RW) begin
            if (RAM_SEL) begin
                DB_OUT = ram[ADDR];
            end else if (!ADDR[2]) begin
                case (ADDR[1:0])
                    2'd0:    DB_OUT = pa_rd;
                    2'd1:    DB_OUT = PA_DIR;
                    2'd2:    DB_OUT = pb_rd;
                    default: DB_OUT = PB_DIR;
                endcase
            end else if (ADDR[0]) begin
                DB_OUT = {tf, pa7f, 6'b0};
            end else begin
                DB_OUT = timer;
            end
        end
    end

endmodule

// File: tb/tb_riot.sv
// Self-checking bench for riot: vector table for RAM/ports, hand sequences for timer, reset and PA7.
module tb_riot;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       CS = 1'b0;
    logic       RAM_SEL = 1'b0;
    logic       RW = 1'b1;
    logic [6:0] ADDR = 7'h00;
    logic [7:0] DB_IN = 8'h00;
    logic [7:0] DB_OUT;
    logic [7:0] PA_IN = 8'hAA;
    logic [7:0] PB_IN = 8'h00;
    logic [7:0] PA_OUT, PB_OUT, PA_DIR, PB_DIR;
    logic       IRQ_N;

    riot #(.P_DDRA_INIT(8'h3C), .P_DDRB_INIT(8'hC3), .P_TIMER_INIT(8'hff)) dut (
        .CLK(CLK), .RES(RES), .CS(CS), .RAM_SEL(RAM_SEL), .RW(RW), .ADDR(ADDR),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .PA_IN(PA_IN), .PB_IN(PB_IN),
        .PA_OUT(PA_OUT), .PB_OUT(PB_OUT), .PA_DIR(PA_DIR), .PB_DIR(PB_DIR),
        .IRQ_N(IRQ_N)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       cs;
        logic       ram;
        logic       wr;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic cs, input logic ram, input logic rw,
                         input logic [6:0] a, input logic [7:0] d);
        CS = cs; RAM_SEL = ram; RW = rw; ADDR = a; DB_IN = d;
    endtask

    task automatic idle();
        CS = 1'b0; RW = 1'b1;
    endtask

    task automatic sample(input logic [7:0] exp, input string nm);
        exp_q.push_back(exp);
        #1;
        chk(nm, DB_OUT, exp_q.pop_front());
    endtask

    task automatic wr(input logic ram, input logic [6:0] a, input logic [7:0] d);
        drive(1'b1, ram, 1'b0, a, d);
        step();
        idle();
    endtask

    task automatic rd(input logic ram, input logic [6:0] a, input logic [7:0] exp, input string nm);
        drive(1'b1, ram, 1'b1, a, 8'h00);
        sample(exp, nm);
        step();
        idle();
    endtask

    // Look at DB_OUT combinationally, dropping CS before any edge can commit side effects.
    task automatic peek(input logic ram, input logic [6:0] a, input logic [7:0] exp, input string nm);
        drive(1'b1, ram, 1'b1, a, 8'h00);
        sample(exp, nm);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        //            cs    ram   wr    addr   data   pa     pb     exp
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 7'h05, 8'hA5, 8'hAA, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 7'h05, 8'h00, 8'hAA, 8'h00, 8'hA5};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 7'h05, 8'h00, 8'hAA, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 7'h05, 8'hFF, 8'hAA, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 7'h05, 8'h00, 8'hAA, 8'h00, 8'hA5};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 7'h7F, 8'h3C, 8'hAA, 8'h00, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 7'h7F, 8'h00, 8'hAA, 8'h00, 8'h3C};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 7'h01, 8'h0F, 8'hAA, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 7'h00, 8'h55, 8'hAA, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 8'hAA, 8'h00, 8'hA5};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 7'h03, 8'hF0, 8'hAA, 8'h34, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 7'h02, 8'h12, 8'hAA, 8'h34, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 7'h02, 8'h00, 8'hAA, 8'h34, 8'h14};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 7'h01, 8'h00, 8'hAA, 8'h34, 8'h0F};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 7'h03, 8'h00, 8'hAA, 8'h34, 8'hF0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 7'h00, 8'h00, 8'hFF, 8'h34, 8'hF5};

        // Reset state
        @(negedge CLK);
        step();
        step();
        RES = 1'b0;
        chk("rst_pa_dir", PA_DIR, 8'h3C);
        chk("rst_pb_dir", PB_DIR, 8'hC3);
        chk("rst_pa_out", PA_OUT, 8'h00);
        chk("rst_pb_out", PB_OUT, 8'h00);
        chk("rst_irq_n", {7'b0, IRQ_N}, 8'h01);
        peek(1'b0, 7'h04, 8'hff, "rst_timer");
        peek(1'b0, 7'h05, 8'h00, "rst_flags");

        // RAM and port table
        for (int i = 0; i < 16; i++) begin
            PA_IN = vecs[i].pa;
            PB_IN = vecs[i].pb;
            if (vecs[i].wr) begin
                drive(vecs[i].cs, vecs[i].ram, 1'b0, vecs[i].addr, vecs[i].data);
                step();
                idle();
            end else begin
                drive(vecs[i].cs, vecs[i].ram, 1'b1, vecs[i].addr, 8'h00);
                sample(vecs[i].exp, $sformatf("vec%0d", i));
                step();
                idle();
            end
        end
        PA_IN = 8'hAA;
        drive(1'b1, 1'b1, 1'b0, 7'h05, 8'h77);
        #1 chk("rw0_dbout", DB_OUT, 8'h00);
        idle();

        // Timer, prescale 8, no IRQ
        wr(1'b0, 7'h15, 8'h02);
        repeat (7) step();
        peek(1'b0, 7'h04, 8'h02, "t_cyc7");
        step();
        peek(1'b0, 7'h04, 8'h01, "t_cyc8");
        repeat (8) step();
        peek(1'b0, 7'h04, 8'h00, "t_cyc16");
        peek(1'b0, 7'h05, 8'h00, "t_flags16");
        repeat (8) step();
        peek(1'b0, 7'h04, 8'hff, "t_cyc24");
        peek(1'b0, 7'h05, 8'h80, "t_flags24");
        chk("t_irq_off", {7'b0, IRQ_N}, 8'h01);
        step();
        peek(1'b0, 7'h04, 8'hfe, "t_cyc25");

        // Timer expiry with IRQ enabled, then cleared by a timer read
        wr(1'b0, 7'h1C, 8'h02);
        repeat (2) step();
        chk("irq_before", {7'b0, IRQ_N}, 8'h01);
        step();
        chk("irq_expire", {7'b0, IRQ_N}, 8'h00);
        rd(1'b0, 7'h04, 8'hff, "irq_rd_timer");
        chk("irq_cleared", {7'b0, IRQ_N}, 8'h01);
        peek(1'b0, 7'h05, 8'h00, "irq_flags_clr");

        // Wrap coincides with a clearing timer read: the set wins
        wr(1'b0, 7'h1C, 8'h00);
        rd(1'b0, 7'h0C, 8'h00, "sw_rd");
        chk("sw_irq_n", {7'b0, IRQ_N}, 8'h00);
        peek(1'b0, 7'h05, 8'h80, "sw_flags");

        // Reset during a timer write
        drive(1'b1, 1'b0, 1'b0, 7'h15, 8'h12);
        RES = 1'b1;
        step();
        RES = 1'b0;
        idle();
        peek(1'b0, 7'h04, 8'hff, "rw_timer");
        chk("rw_pa_dir", PA_DIR, 8'h3C);
        chk("rw_pb_dir", PB_DIR, 8'hC3);
        chk("rw_pa_out", PA_OUT, 8'h00);
        chk("rw_irq_n", {7'b0, IRQ_N}, 8'h01);
        repeat (1023) step();
        peek(1'b0, 7'h04, 8'hff, "rw_cnt1023");
        step();
        peek(1'b0, 7'h04, 8'hfe, "rw_cnt1024");

        // PA7 edge detector: rising edge selected, IRQ enabled
        wr(1'b0, 7'h07, 8'h00);
        PA_IN = 8'h00;
        step();
        step();
        peek(1'b0, 7'h05, 8'h00, "pa7_fall_ign");
        chk("pa7_irq_idle", {7'b0, IRQ_N}, 8'h01);
        PA_IN = 8'h80;
        step();
`ifdef RIOT_PA7_IRQ_EN
        peek(1'b0, 7'h05, 8'h40, "pa7_flag");
        chk("pa7_irq_n", {7'b0, IRQ_N}, 8'h00);
        rd(1'b0, 7'h05, 8'h40, "pa7_rd");
`else
        peek(1'b0, 7'h05, 8'h00, "pa7_flag");
        chk("pa7_irq_n", {7'b0, IRQ_N}, 8'h01);
        rd(1'b0, 7'h05, 8'h00, "pa7_rd");
`endif
        peek(1'b0, 7'h05, 8'h00, "pa7_reread");
        chk("pa7_irq_clr", {7'b0, IRQ_N}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riot.md
RIOT -- requirements
Module: riot

Interface
REQ-001 Parameter P_DDRA_INIT, 8'h00, reset value of port A direction register.
REQ-002 Parameter P_DDRB_INIT, 8'h00, reset value of port B direction register.
REQ-003 Parameter P_TIMER_INIT, 8'hff, reset value of interval timer.
REQ-004 CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 RES  input  1  reset, synchronous, active-high.
REQ-006 CS  input  1  chip select; 0 = no access, no side effects.
REQ-007 RAM_SEL  input  1  1 = RAM space, 0 = I/O/timer space.
REQ-008 RW  input  1  1 = CPU read, 0 = CPU write.
REQ-009 ADDR  input  7  address from CPU address bus (ABL[6:0]).
REQ-010 DB_IN  input  8  write data from CPU DB_OUT.
REQ-011 DB_OUT  output  8  read data to CPU DB_IN.
REQ-012 PA_IN, PB_IN  input  8 each  external port pins.
REQ-013 PA_OUT, PB_OUT  output  8 each  output data registers.
REQ-014 PA_DIR, PB_DIR  output  8 each  direction registers, bit 1 = output.
REQ-015 IRQ_N  output  1  interrupt request to CPU, active-low.

Function
REQ-016 Writes commit on rising edge when CS=1, RW=0; read side effects commit on rising edge when CS=1, RW=1.
REQ-017 DB_OUT combinational from current CS/RAM_SEL/RW/ADDR, zero latency; 8'h00 when CS=0 or RW=0.
REQ-018 RAM: 128x8, ADDR selects byte, asynchronous read, write on edge; contents not reset.
REQ-019 RAM_SEL=0, ADDR[2]=0: ADDR[1:0] = 0 PA data, 1 DDRA, 2 PB data, 3 DDRB.
REQ-020 Port data read = (PIN & ~DIR) | (OUT & DIR), per port.
REQ-021 RAM_SEL=0, ADDR[2]=1, ADDR[4]=1 write: load timer with DB_IN, prescale select = ADDR[1:0] (0:1, 1:8, 2:64, 3:1024 cycles), timer IRQ enable = ADDR[3], clear TF.
REQ-022 Prescale counter (10 bit) reloads to interval-1 on load; timer decrements by 1 when prescale counter = 0, then reloads.
REQ-023 Timer at 8'h00 with decrement due: wraps to 8'hff, sets TF, prescale forced to 1 until next load.
REQ-024 RAM_SEL=0, ADDR[2]=1, ADDR[0]=0 read: returns timer, sets timer IRQ enable = ADDR[3], clears TF.
REQ-025 RAM_SEL=0, ADDR[2]=1, ADDR[0]=1 read: returns {TF, PA7F, 6'b0}, clears PA7F.
REQ-026 Simultaneous load and decrement: load wins; simultaneous TF set and clearing read: set wins.
REQ-027 IRQ_N = ~((TF & timer IRQ enable) | (PA7F & PA7 IRQ enable)).
REQ-028 RAM_SEL=0 accesses not listed above: reads return 8'h00, writes ignored unless REQ-040 applies.

Reset
REQ-029 RES=1 at rising edge overrides any concurrent access.
REQ-030 Reset values: PA_OUT=PB_OUT=8'h00, PA_DIR=P_DDRA_INIT, PB_DIR=P_DDRB_INIT, timer=P_TIMER_INIT, prescale select = 1024, prescale counter = 1023.
REQ-031 Reset values: TF=0, PA7F=0, all IRQ enables 0, IRQ_N=1.
REQ-032 Reset mid-countdown abandons the count; counting resumes from reset values on the first cycle after RES deasserts.

Configuration
REQ-033 Macro RIOT_PA7_IRQ_EN compiles in the PA7 edge detector.
REQ-034 Defined: PA7 sampled each cycle; the selected edge (REQ-040) sets PA7F.
REQ-035 Defined: sampled PA7 register resets to 0.
REQ-036 Not defined: PA7F constant 0, edge-control writes ignored, PA7 term absent from IRQ_N.
REQ-037 Not defined: all other behaviour identical.
REQ-038 PA7 edge-control setting (REQ-040) resets to falling edge, IRQ disabled.
REQ-039 Edge detection and flag set/clear follow REQ-016/REQ-026 priority (set wins).
REQ-040 RAM_SEL=0, ADDR[2]=1, ADDR[4]=0 write: ADDR[0] = edge polarity (1 rising), ADDR[1] = PA7 IRQ enable.

Verification
REQ-041 Write RAM 7'h05=8'hA5, read 7'h05 -> DB_OUT 8'hA5; read with CS=0 -> 8'h00.
REQ-042 DDRA=8'h0F, PA_OUT reg=8'h55, PA_IN=8'hAA -> PA read 8'hA5.
REQ-043 Load timer 8'h02, prescale 8 (ADDR=7'h15) -> timer 01 after 8 cycles, 00 after 16, ff with TF=1 after 24, fe one cycle later.
REQ-044 Load with ADDR[3]=1, let expire -> IRQ_N=0; timer read (ADDR=7'h04) -> TF=0, IRQ_N=1 next cycle.
REQ-045 With RIOT_PA7_IRQ_EN, rising edge selected with IRQ enabled, PA_IN[7] 0->1 -> flags read 8'h40, IRQ_N=0; flags reread -> 8'h00.
REQ-046 RES=1 during a timer write -> timer 8'hff, DIR registers at parameter values, IRQ_N=1.
